// File: rtl/nms_suppress_if.sv
// nms_suppress_if
//   Stream bundle for the non-maximum suppression stage: the gradient input
//   stream (magnitude, direction, valid/ready) and the thinned output stream
//   (magnitude, coordinates, last flag). The output side has no backpressure.
//
//   Modports:
//     master : upstream/downstream side (drives the gradient input, observes output)
//     slave  : the nms_suppress block
//
//   Signals:
//     mag_in[MAG_W]       gradient magnitude
//     dir_in[2]           quantised direction (0=0deg, 1=45deg, 2=90deg, 3=135deg)
//     in_valid / in_ready input handshake, beat accepted when both high
//     nms_magnitude       suppressed magnitude
//     nms_valid           nms_magnitude valid this cycle
//     out_x / out_y       column / row of the output pixel
//     out_last            final output pixel of a frame
interface nms_suppress_if #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int MAG_W      = 11
);
  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = $clog2(IMG_HEIGHT);

  logic [MAG_W-1:0] mag_in;
  logic [1:0]       dir_in;
  logic             in_valid;
  logic             in_ready;
  logic [MAG_W-1:0] nms_magnitude;
  logic             nms_valid;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic             out_last;

  modport master (
    output mag_in, dir_in, in_valid,
    input  in_ready, nms_magnitude, nms_valid, out_x, out_y, out_last
  );

  modport slave (
    input  mag_in, dir_in, in_valid,
    output in_ready, nms_magnitude, nms_valid, out_x, out_y, out_last
  );
endinterface

// File: rtl/nms_suppress.sv
// nms_suppress
//   Non-maximum suppression for the Canny edge pipeline. Gradient magnitude and
//   quantised direction arrive in raster order; a 3x3 window built from two line
//   buffers and a window register compares each centre pixel against the two
//   neighbours along its gradient direction. The centre survives if it is >= both
//   (ties keep), otherwise it becomes 0. Border pixels output 0.
//
//   After the last input pixel, IMG_WIDTH+1 internal flush beats (magnitude 0,
//   direction 0) push the final row through the window while in_ready is low.
//
//   Ports:
//     clk   : clock, rising edge
//     rstN  : asynchronous active-low reset
//     bus   : nms_suppress_if.slave (input stream, output stream)
//
//   Build option:
//     NMS_BORDER_KEEP_EN : when defined, border pixels output their own
//                          unsuppressed magnitude instead of 0.
module nms_suppress #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int MAG_W      = 11
) (
  input  logic          clk,
  input  logic          rstN,
  nms_suppress_if.slave bus
);
  localparam int X_W   = $clog2(IMG_WIDTH);
  localparam int Y_W   = $clog2(IMG_HEIGHT);
  localparam int F_W   = $clog2(IMG_WIDTH + 1);
  localparam int PIX_W = MAG_W + 2;

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);
  localparam logic [F_W-1:0] F_LAST = F_W'(IMG_WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_FLUSH} state_t;

  function automatic logic [MAG_W-1:0] keep_if_max(input logic [MAG_W-1:0] c,
                                                   input logic [MAG_W-1:0] a,
                                                   input logic [MAG_W-1:0] b);
    return (c >= a && c >= b) ? c : '0;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [X_W-1:0]   r_col;
  logic [Y_W-1:0]   r_row;
  logic [F_W-1:0]   r_fcnt;
  logic [X_W-1:0]   r_wp;

  logic             w_acc;
  logic             w_flush;
  logic             w_beat;
  logic             w_fill_done;
  logic             w_frame_end;
  logic             w_flush_done;
  logic [PIX_W-1:0] w_pix_in;

  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_win_p0 [3][3];
  logic             r_vld_p0;
  logic [X_W-1:0]   r_ox_p0;
  logic [Y_W-1:0]   r_oy_p0;

  logic [1:0]       w_dir_p0;
  logic [MAG_W-1:0] w_c_p0;
  logic [MAG_W-1:0] w_na_p0;
  logic [MAG_W-1:0] w_nb_p0;
  logic             w_border_p0;
  logic             w_last_p0;
  logic [MAG_W-1:0] w_res_p0;

  logic [MAG_W-1:0] r_mag_p1;
  logic             r_vld_p1;
  logic [X_W-1:0]   r_x_p1;
  logic [Y_W-1:0]   r_y_p1;
  logic             r_last_p1;

  assign bus.in_ready = (r_state != ST_FLUSH);
  assign w_acc        = bus.in_valid && bus.in_ready;
  assign w_flush      = (r_state == ST_FLUSH);
  assign w_beat       = w_acc || w_flush;
  // Pixel (1,0) is the (IMG_WIDTH+1)-th beat; the next beat puts (0,0) in the centre.
  assign w_fill_done  = w_acc && (r_row == Y_W'(1)) && (r_col == '0);
  assign w_frame_end  = w_acc && (r_row == Y_LAST) && (r_col == X_LAST);
  assign w_flush_done = (r_fcnt == F_LAST);
  assign w_pix_in     = w_flush ? '0 : {bus.dir_in, bus.mag_in};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_acc)        w_state_nxt = ST_FILL;
      ST_FILL:  if (w_fill_done)  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_frame_end)  w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_flush_done) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= ST_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_fcnt   <= '0;
      r_wp     <= '0;
      r_vld_p0 <= 1'b0;
      r_ox_p0  <= '0;
      r_oy_p0  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) begin
        if (r_col == X_LAST) begin
          r_col <= '0;
          r_row <= (r_row == Y_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      r_fcnt <= (w_flush && !w_flush_done) ? r_fcnt + 1'b1 : '0;
      // The line buffers are pure IMG_WIDTH-deep delay lines, so the write
      // pointer only needs to cycle, not to track the image column.
      if (w_beat) r_wp <= (r_wp == X_LAST) ? '0 : r_wp + 1'b1;
      r_vld_p0 <= w_beat && (r_state == ST_RUN || r_state == ST_FLUSH);
      // Centre coordinate of the window; exactly W*H valid updates per frame
      // bring it back to (0,0) for the next frame.
      if (r_vld_p0) begin
        if (r_ox_p0 == X_LAST) begin
          r_ox_p0 <= '0;
          r_oy_p0 <= (r_oy_p0 == Y_LAST) ? '0 : r_oy_p0 + 1'b1;
        end else begin
          r_ox_p0 <= r_ox_p0 + 1'b1;
        end
      end
    end
  end

  // ---- stage p0: line buffers and 3x3 window (rows r-1, r, r+1; col 2 newest)
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_lb1[r_wp] <= r_lb0[r_wp];
      r_lb0[r_wp] <= w_pix_in;
      for (int i = 0; i < 3; i++) begin
        r_win_p0[i][0] <= r_win_p0[i][1];
        r_win_p0[i][1] <= r_win_p0[i][2];
      end
      r_win_p0[0][2] <= r_lb1[r_wp];
      r_win_p0[1][2] <= r_lb0[r_wp];
      r_win_p0[2][2] <= w_pix_in;
    end
  end

  always_comb begin
    w_dir_p0 = r_win_p0[1][1][PIX_W-1 -: 2];
    w_c_p0   = r_win_p0[1][1][MAG_W-1:0];
    w_na_p0  = '0;
    w_nb_p0  = '0;
    unique case (w_dir_p0)
      2'd0: begin w_na_p0 = r_win_p0[1][0][MAG_W-1:0]; w_nb_p0 = r_win_p0[1][2][MAG_W-1:0]; end
      2'd1: begin w_na_p0 = r_win_p0[0][2][MAG_W-1:0]; w_nb_p0 = r_win_p0[2][0][MAG_W-1:0]; end
      2'd2: begin w_na_p0 = r_win_p0[0][1][MAG_W-1:0]; w_nb_p0 = r_win_p0[2][1][MAG_W-1:0]; end
      default: begin w_na_p0 = r_win_p0[0][0][MAG_W-1:0]; w_nb_p0 = r_win_p0[2][2][MAG_W-1:0]; end
    endcase
    // Border windows contain wrapped or stale pixels, so they never reach the compare.
    w_border_p0 = (r_ox_p0 == '0) || (r_ox_p0 == X_LAST) ||
                  (r_oy_p0 == '0) || (r_oy_p0 == Y_LAST);
    w_last_p0   = (r_ox_p0 == X_LAST) && (r_oy_p0 == Y_LAST);
`ifdef NMS_BORDER_KEEP_EN
    w_res_p0 = w_border_p0 ? w_c_p0 : keep_if_max(w_c_p0, w_na_p0, w_nb_p0);
`else
    w_res_p0 = w_border_p0 ? '0 : keep_if_max(w_c_p0, w_na_p0, w_nb_p0);
`endif
  end

  // ---- stage p1: registered output
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_mag_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_x_p1    <= '0;
      r_y_p1    <= '0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_vld_p0 && w_last_p0;
      if (r_vld_p0) begin
        r_mag_p1 <= w_res_p0;
        r_x_p1   <= r_ox_p0;
        r_y_p1   <= r_oy_p0;
      end
    end
  end

  assign bus.nms_magnitude = r_mag_p1;
  assign bus.nms_valid     = r_vld_p1;
  assign bus.out_x         = r_x_p1;
  assign bus.out_y         = r_y_p1;
  assign bus.out_last      = r_last_p1;
endmodule

// File: tb/tb_nms_suppress.sv
// tb_nms_suppress
//   Bench for nms_suppress on a 4x4 frame. Frames are held as plain pixel
//   arrays; the expected output of each pixel is derived from the image itself
//   (border rule, direction as an offset vector and its opposite, keep if >= both).
module tb_nms_suppress;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int MW = 11;
  localparam int N  = W * H;
`ifdef NMS_BORDER_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  nms_suppress_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW)) bus ();

  nms_suppress #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_W(MW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int unsigned img_mag [2][N];
  int          img_dir [2][N];
  int          acc_cyc [2][N];

  int unsigned cap_mag  [$];
  int          cap_pos  [$];
  bit          cap_last [$];
  int          cap_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstN && bus.nms_valid) begin
      cap_mag.push_back(bus.nms_magnitude);
      cap_pos.push_back(int'(bus.out_y) * W + int'(bus.out_x));
      cap_last.push_back(bus.out_last);
      cap_cyc.push_back(cyc);
    end
  end

  function automatic int unsigned ref_pix(input int f, input int p);
    int r, c, dr, dc;
    int unsigned m, a, b;
    r = p / W;
    c = p % W;
    m = img_mag[f][p];
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return KEEP ? m : 0;
    case (img_dir[f][p])
      0:       begin dr = 0;  dc = 1;  end
      1:       begin dr = -1; dc = 1;  end
      2:       begin dr = -1; dc = 0;  end
      default: begin dr = -1; dc = -1; end
    endcase
    a = img_mag[f][(r + dr) * W + (c + dc)];
    b = img_mag[f][(r - dr) * W + (c - dc)];
    return (m >= a && m >= b) ? m : 0;
  endfunction

  task automatic clear_caps();
    cap_mag.delete(); cap_pos.delete(); cap_last.delete(); cap_cyc.delete();
  endtask

  task automatic fill_const(input int f, input int unsigned m, input int d);
    for (int p = 0; p < N; p++) begin img_mag[f][p] = m; img_dir[f][p] = d; end
  endtask

  task automatic fill_rand(input int f, input int unsigned maxv);
    for (int p = 0; p < N; p++) begin
      img_mag[f][p] = $urandom_range(0, maxv);
      img_dir[f][p] = $urandom_range(0, 3);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the last accept.
  task automatic drive_frame(input int f, input bit gaps, input int npix);
    int guard;
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin bus.in_valid = 1'b0; @(negedge clk); end
      end
      bus.mag_in   = MW'(img_mag[f][p]);
      bus.dir_in   = 2'(img_dir[f][p]);
      bus.in_valid = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin @(negedge clk); guard++; end
      if (guard >= 100) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: frame %0d pixel %0d never accepted, in_ready=%0b required 1", f, p, bus.in_ready);
      end
      acc_cyc[f][p] = cyc + 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, output bit ok);
    int guard = 0;
    while (cap_mag.size() < n && guard < 400) begin @(negedge clk); guard++; end
    repeat (4) @(negedge clk);
    ok = (cap_mag.size() == n);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.nms_valid, bus.nms_magnitude, bus.out_x, bus.out_y, bus.out_last, bus.in_ready} !==
          {1'b0, MW'(0), 2'd0, 2'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_values: valid=%0b mag=%0d x=%0d y=%0d last=%0b ready=%0b required 0/0/0/0/0/1",
                 bus.nms_valid, bus.nms_magnitude, bus.out_x, bus.out_y, bus.out_last, bus.in_ready);
      end
    end
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.nms_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%0b ready=%0b required 0/1", bus.nms_valid, bus.in_ready);
    end
  endtask

  task automatic test_flat();
    bit ok;
    int n;
    fill_const(0, 50, 0);
    clear_caps();
    drive_frame(0, 1'b0, N);
    n = 0;
    while (!bus.in_ready && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (n != W + 1) begin errors++; $display("FAIL flat_ready_low: low %0d cycles required %0d", n, W + 1); end
    wait_outputs(N, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flat_count: got %0d outputs required %0d", cap_mag.size(), N); end
    for (int i = 0; i < N && i < cap_mag.size(); i++) begin
      checks++;
      if (cap_mag[i] !== ref_pix(0, i) || cap_pos[i] !== i || cap_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL flat_out%0d: mag=%0d pos=%0d last=%0b required mag=%0d pos=%0d last=%0b",
                 i, cap_mag[i], cap_pos[i], cap_last[i], ref_pix(0, i), i, (i == N - 1));
      end
    end
    if (cap_mag.size() == N) begin
      checks++;
      if (cap_mag[5] !== 50 || cap_mag[0] !== (KEEP ? 50 : 0) || cap_last[15] !== 1'b1) begin
        errors++;
        $display("FAIL flat_const: mag(1,1)=%0d mag(0,0)=%0d last16=%0b required 50/%0d/1",
                 cap_mag[5], cap_mag[0], cap_last[15], KEEP ? 50 : 0);
      end
      checks++;
      if (cap_cyc[5] - acc_cyc[0][5] !== W + 2) begin
        errors++;
        $display("FAIL flat_latency: %0d cycles required %0d", cap_cyc[5] - acc_cyc[0][5], W + 2);
      end
    end
  endtask

  task automatic test_peak();
    bit ok;
    fill_const(0, 50, 0);
    img_mag[0][5] = 100;
    img_mag[0][6] = 120;
    clear_caps();
    drive_frame(0, 1'b0, N);
    wait_outputs(N, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL peak_count: got %0d outputs required %0d", cap_mag.size(), N); end
    for (int i = 0; i < N && i < cap_mag.size(); i++) begin
      checks++;
      if (cap_mag[i] !== ref_pix(0, i) || cap_pos[i] !== i) begin
        errors++;
        $display("FAIL peak_out%0d: mag=%0d pos=%0d required mag=%0d pos=%0d", i, cap_mag[i], cap_pos[i], ref_pix(0, i), i);
      end
    end
    if (cap_mag.size() == N) begin
      checks++;
      if (cap_mag[5] !== 0 || cap_mag[6] !== 120) begin
        errors++;
        $display("FAIL peak_const: mag(1,1)=%0d mag(1,2)=%0d required 0/120", cap_mag[5], cap_mag[6]);
      end
    end
  endtask

  task automatic test_diag();
    bit ok;
    int diag_dir [3] = '{1, 3, 2};
    int diag_exp [3] = '{0, 80, 80};
    for (int k = 0; k < 3; k++) begin
      fill_const(0, 10, 0);
      img_mag[0][5] = 80;
      img_dir[0][5] = diag_dir[k];
      if (k == 0) img_mag[0][2] = 90;
      if (k == 1) begin img_mag[0][2] = 90; img_mag[0][0] = 10; img_mag[0][10] = 10; end
      if (k == 2) begin img_mag[0][1] = 80; img_mag[0][9] = 79; end
      clear_caps();
      drive_frame(0, 1'b0, N);
      wait_outputs(N, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL diag%0d_count: got %0d outputs required %0d", k, cap_mag.size(), N); end
      for (int i = 0; i < N && i < cap_mag.size(); i++) begin
        checks++;
        if (cap_mag[i] !== ref_pix(0, i)) begin
          errors++;
          $display("FAIL diag%0d_out%0d: mag=%0d required %0d", k, i, cap_mag[i], ref_pix(0, i));
        end
      end
      if (cap_mag.size() == N) begin
        checks++;
        if (cap_mag[5] !== diag_exp[k]) begin
          errors++;
          $display("FAIL diag%0d_centre: mag=%0d required %0d", k, cap_mag[5], diag_exp[k]);
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    bit ok;
    int n;
    for (int rep = 0; rep < 3; rep++) begin
      fill_rand(0, (rep == 0) ? 15 : 2047);
      clear_caps();
      drive_frame(0, 1'b1, N);
      n = 0;
      while (!bus.in_ready && n < 50) begin n++; @(negedge clk); end
      checks++;
      if (n != W + 1) begin errors++; $display("FAIL gaps%0d_ready_low: low %0d cycles required %0d", rep, n, W + 1); end
      wait_outputs(N, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL gaps%0d_count: got %0d outputs required %0d", rep, cap_mag.size(), N); end
      for (int i = 0; i < N && i < cap_mag.size(); i++) begin
        checks++;
        if (cap_mag[i] !== ref_pix(0, i) || cap_pos[i] !== i || cap_last[i] !== (i == N - 1)) begin
          errors++;
          $display("FAIL gaps%0d_out%0d: mag=%0d pos=%0d last=%0b required mag=%0d pos=%0d last=%0b",
                   rep, i, cap_mag[i], cap_pos[i], cap_last[i], ref_pix(0, i), i, (i == N - 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_rand(0, 31);
    fill_rand(1, 31);
    clear_caps();
    drive_frame(0, 1'b0, N);
    drive_frame(1, 1'b0, N);
    wait_outputs(2 * N, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_count: got %0d outputs required %0d", cap_mag.size(), 2 * N); end
    for (int i = 0; i < 2 * N && i < cap_mag.size(); i++) begin
      checks++;
      if (cap_mag[i] !== ref_pix(i / N, i % N) || cap_pos[i] !== i % N || cap_last[i] !== (i % N == N - 1)) begin
        errors++;
        $display("FAIL b2b_out%0d: mag=%0d pos=%0d last=%0b required mag=%0d pos=%0d last=%0b",
                 i, cap_mag[i], cap_pos[i], cap_last[i], ref_pix(i / N, i % N), i % N, (i % N == N - 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_const(0, 2000, 3);
    drive_frame(0, 1'b0, 7);
    rstN = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.nms_valid, bus.nms_magnitude, bus.out_x, bus.out_y, bus.out_last, bus.in_ready} !==
          {1'b0, MW'(0), 2'd0, 2'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL midreset_values%0d: valid=%0b mag=%0d x=%0d y=%0d last=%0b ready=%0b required 0/0/0/0/0/1",
                 k, bus.nms_valid, bus.nms_magnitude, bus.out_x, bus.out_y, bus.out_last, bus.in_ready);
      end
      @(negedge clk);
    end
    rstN = 1'b1;
    @(negedge clk);
    fill_rand(0, 63);
    clear_caps();
    drive_frame(0, 1'b0, N);
    wait_outputs(N, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_count: got %0d outputs required %0d", cap_mag.size(), N); end
    for (int i = 0; i < N && i < cap_mag.size(); i++) begin
      checks++;
      if (cap_mag[i] !== ref_pix(0, i) || cap_pos[i] !== i || cap_last[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL midreset_out%0d: mag=%0d pos=%0d last=%0b required mag=%0d pos=%0d last=%0b",
                 i, cap_mag[i], cap_pos[i], cap_last[i], ref_pix(0, i), i, (i == N - 1));
      end
    end
  endtask

  task automatic test_border();
    bit ok;
    for (int p = 0; p < N; p++) begin
      if (p / W == 0 || p / W == H - 1 || p % W == 0 || p % W == W - 1) img_mag[0][p] = 33;
      else img_mag[0][p] = $urandom_range(20, 60);
      img_dir[0][p] = $urandom_range(0, 3);
    end
    clear_caps();
    drive_frame(0, 1'b0, N);
    wait_outputs(N, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL border_count: got %0d outputs required %0d", cap_mag.size(), N); end
    for (int i = 0; i < N && i < cap_mag.size(); i++) begin
      checks++;
      if (cap_mag[i] !== ref_pix(0, i)) begin
        errors++;
        $display("FAIL border_out%0d: mag=%0d required %0d", i, cap_mag[i], ref_pix(0, i));
      end
    end
    if (cap_mag.size() == N) begin
      checks++;
      if (cap_mag[0] !== (KEEP ? 33 : 0) || cap_mag[15] !== (KEEP ? 33 : 0) || cap_mag[7] !== (KEEP ? 33 : 0)) begin
        errors++;
        $display("FAIL border_const: mag(0,0)=%0d mag(1,3)=%0d mag(3,3)=%0d required %0d",
                 cap_mag[0], cap_mag[7], cap_mag[15], KEEP ? 33 : 0);
      end
    end
  endtask

  initial begin
    bus.mag_in   = '0;
    bus.dir_in   = '0;
    bus.in_valid = 1'b0;
    rstN         = 1'b0;
    test_reset();
    test_flat();
    test_peak();
    test_diag();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid();
    test_border();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
